aes_mixcol_engine: RTL

- Iterative AES MixColumns / InvMixColumns engine over a full 128-bit state.
- Processes COLS_PER_CYCLE columns per clock using GF(2^8) constant multipliers (x2, x3, x9, x11, x13, x14), with mode selected per transaction.
- Sits between ShiftRows and AddRoundKey in the AES accelerator datapath.
- Uses a valid/ready handshake on both sides and handles one transaction at a time.

---
 rtl/aes_mixcol_engine.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/aes_mixcol_engine.sv
// Iterative AES MixColumns / InvMixColumns engine over a 128-bit state.
// Transforms COLS_PER_CYCLE columns per clock, in place, with valid/ready on both sides.
module aes_mixcol_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         inv_i,
    input  logic [127:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] data_o,
    output logic         busy_o
);
    localparam int NUM_STEPS = 4 / COLS_PER_CYCLE;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         inv_q, inv_d;
    logic [127:0] data_q, data_d;

    function automatic logic [7:0] x2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] x3(input logic [7:0] b);
        return x2(b) ^ b;
    endfunction

    function automatic logic [7:0] x9(input logic [7:0] b);
        return x2(x2(x2(b))) ^ b;
    endfunction

    function automatic logic [7:0] x11(input logic [7:0] b);
        return x2(x2(x2(b))) ^ x2(b) ^ b;
    endfunction

    function automatic logic [7:0] x13(input logic [7:0] b);
        return x2(x2(x2(b))) ^ x2(x2(b)) ^ b;
    endfunction

    function automatic logic [7:0] x14(input logic [7:0] b);
        return x2(x2(x2(b))) ^ x2(x2(b)) ^ x2(b);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] c, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        if (!inv) begin
            b0 = x2(a0) ^ x3(a1) ^ a2 ^ a3;
            b1 = a0 ^ x2(a1) ^ x3(a2) ^ a3;
            b2 = a0 ^ a1 ^ x2(a2) ^ x3(a3);
            b3 = x3(a0) ^ a1 ^ a2 ^ x2(a3);
        end else begin
            b0 = x14(a0) ^ x11(a1) ^ x13(a2) ^ x9(a3);
            b1 = x9(a0) ^ x14(a1) ^ x11(a2) ^ x13(a3);
            b2 = x13(a0) ^ x9(a1) ^ x14(a2) ^ x11(a3);
            b3 = x11(a0) ^ x13(a1) ^ x9(a2) ^ x14(a3);
        end
        return {b0, b1, b2, b3};
    endfunction

    // Only COLS_PER_CYCLE mixers exist; each lane is steered to its column by the counter.
    logic [31:0] cols     [4];
    logic [31:0] ncols    [4];
    logic [1:0]  lane_idx [COLS_PER_CYCLE];
    logic [31:0] lane_out [COLS_PER_CYCLE];

    for (genvar c = 0; c < 4; c++) begin : g_cols
        assign cols[c] = data_q[127-32*c -: 32];
    end

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lanes
        assign lane_idx[k] = 2'(int'(cnt_q) * COLS_PER_CYCLE + k);
        assign lane_out[k] = mix(cols[lane_idx[k]], inv_q);
    end

    always_comb begin
        ncols = cols;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            ncols[lane_idx[k]] = lane_out[k];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    data_d  = data_i;
                    inv_d   = inv_i;
                    cnt_d   = 2'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                data_d = {ncols[0], ncols[1], ncols[2], ncols[3]};
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'(NUM_STEPS - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            inv_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign valid_o = (state_q == S_DONE);
    assign busy_o  = (state_q != S_IDLE);
    assign data_o  = data_q;

endmodule
